mix_columns_engine: RTL and testbench



---
 rtl/mix_columns_engine.sv | 154 +++++++++++++++
 tb/tb_mix_columns_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready on both sides.
// COLS_PER_CYCLE columns are mixed in place per clock; one state per transaction.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inverse,
  output logic         busy
);

  localparam int NUM_BEATS = 4 / COLS_PER_CYCLE;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [127:0]        work_q, work_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                mode_q, mode_d;
  logic                out_inverse_q, out_inverse_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Multiples are composed from x2/x4/x8 chains: 3=2^1, 9=8^1, b=8^2^1, d=8^4^1, e=8^4^2.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] ka [4];
    logic [7:0] kb [4];
    logic [7:0] kc [4];
    logic [7:0] kd [4];
    logic [31:0] res;
    res = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      b[j]  = col[31-8*j -: 8];
      x2[j] = xtime(b[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
      if (inv) begin
        ka[j] = x8[j] ^ x4[j] ^ x2[j];
        kb[j] = x8[j] ^ x2[j] ^ b[j];
        kc[j] = x8[j] ^ x4[j] ^ b[j];
        kd[j] = x8[j] ^ b[j];
      end else begin
        ka[j] = x2[j];
        kb[j] = x2[j] ^ b[j];
        kc[j] = b[j];
        kd[j] = b[j];
      end
    end
    for (int unsigned j = 0; j < 4; j++) begin
      res[31-8*j -: 8] = ka[j] ^ kb[(j+1)%4] ^ kc[(j+2)%4] ^ kd[(j+3)%4];
    end
    return res;
  endfunction

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    work_d        = work_q;
    out_data_d    = out_data_q;
    mode_d        = mode_q;
    out_inverse_d = out_inverse_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d     = in_data;
          mode_d     = in_inverse;
          beat_d     = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end
      CALC: begin
        for (int unsigned c = 0; c < 4; c++) begin
          if (BEAT_W'(c / unsigned'(COLS_PER_CYCLE)) == beat_q) begin
            work_d[127-32*c -: 32] = mix_column(work_q[127-32*c -: 32], mode_q);
          end
        end
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
          out_data_d    = work_d;
          out_inverse_d = mode_q;
          out_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      work_q        <= '0;
      out_data_q    <= '0;
      mode_q        <= 1'b0;
      out_inverse_q <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      work_q        <= work_d;
      out_data_q    <= out_data_d;
      mode_q        <= mode_d;
      out_inverse_q <= out_inverse_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inverse = out_inverse_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2, 4 columns per cycle)
// checked against a generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_engine;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [127:0] in_data;
  logic         in_inverse;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] out_data [3];
  logic [2:0]   out_inverse;
  logic [2:0]   busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_data    (in_data),
      .in_inverse (in_inverse),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .out_inverse(out_inverse[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Drives one transaction on instance k; lat = cycles from accept edge to out_valid,
  // or -1 if the engine never became ready.
  task automatic run_txn(input int k, input logic [127:0] d, input logic inv, input bit scramble,
                         output logic [127:0] res, output logic res_inv, output int lat);
    int guard;
    res = '0; res_inv = 1'b0; lat = 0;
    in_data = d; in_inverse = inv; in_valid[k] = 1'b1;
    guard = 0;
    while (!in_ready[k] && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready[k]) begin
      in_valid[k] = 1'b0; lat = -1; return;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    while (!out_valid[k] && lat < 20) begin
      if (scramble) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_inverse = 1'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    res = out_data[k]; res_inv = out_inverse[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = '0; out_ready = '0; in_data = '0; in_inverse = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({in_ready[k], out_valid[k], busy[k], out_inverse[k]} !== 4'b1000) begin
        n_err++; $display("FAIL reset_flags inst %0d: got rdy/vld/busy/inv=%b%b%b%b want 1000",
                          k, in_ready[k], out_valid[k], busy[k], out_inverse[k]);
      end
      n_cmp++;
      if (out_data[k] !== 128'h0) begin
        n_err++; $display("FAIL reset_data inst %0d: got %h want 0", k, out_data[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors;
    logic [127:0] ins  [3];
    logic [127:0] exps [3];
    logic         invs [3];
    logic [127:0] res;
    logic         ri;
    int           lat;
    ins[0] = V_PLAIN; exps[0] = V_MIXED; invs[0] = 1'b0;
    ins[1] = V_MIXED; exps[1] = V_PLAIN; invs[1] = 1'b1;
    ins[2] = V2_IN;   exps[2] = V2_OUT;  invs[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 3; v++) begin
        run_txn(k, ins[v], invs[v], 1'b0, res, ri, lat);
        n_cmp++;
        if (res !== exps[v]) begin
          n_err++; $display("FAIL vector%0d_data inst %0d: got %h want %h", v, k, res, exps[v]);
        end
        n_cmp++;
        if (ri !== invs[v]) begin
          n_err++; $display("FAIL vector%0d_inverse inst %0d: got %b want %b", v, k, ri, invs[v]);
        end
        n_cmp++;
        if (lat != (4 >> k)) begin
          n_err++; $display("FAIL vector%0d_latency inst %0d: got %0d want %0d", v, k, lat, 4 >> k);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] held;
    int guard;
    in_data = V_MIXED; in_inverse = 1'b1; in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    guard = 0;
    while (!out_valid[1] && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    held = out_data[1];
    n_cmp++;
    if (held !== V_PLAIN) begin
      n_err++; $display("FAIL bp_first_data: got %h want %h", held, V_PLAIN);
    end
    for (int i = 0; i < 10; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom}; in_inverse = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid[1], in_ready[1], busy[1], out_inverse[1]} !== 4'b1011 || out_data[1] !== held) begin
        n_err++; $display("FAIL bp_hold cycle %0d: got vld/rdy/busy/inv=%b%b%b%b data %h want 1011 data %h",
                          i, out_valid[1], in_ready[1], busy[1], out_inverse[1], out_data[1], held);
      end
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    out_ready[1] = 1'b0;
    n_cmp++;
    if ({out_valid[1], in_ready[1], busy[1]} !== 3'b010 || out_data[1] !== held) begin
      n_err++; $display("FAIL bp_release: got vld/rdy/busy=%b%b%b data %h want 010 data %h",
                        out_valid[1], in_ready[1], busy[1], out_data[1], held);
    end
  endtask

  task automatic test_reset_midcalc;
    int lat;
    in_data = V2_IN; in_inverse = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid[0], in_ready[0], busy[0]} !== 3'b010 || out_data[0] !== 128'h0) begin
      n_err++; $display("FAIL midcalc_reset: got vld/rdy/busy=%b%b%b data %h want 010 data 0",
                        out_valid[0], in_ready[0], busy[0], out_data[0]);
    end
    in_data = V_PLAIN; in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
        n_err++; $display("FAIL reset_ignores_valid cycle %0d: got busy=%b vld=%b want 0 0", i, busy[0], out_valid[0]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n_cmp++;
    if (busy[0] !== 1'b1) begin
      n_err++; $display("FAIL accept_after_reset: got busy=%b want 1", busy[0]);
    end
    lat = 0;
    while (!out_valid[0] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat != 4 || out_data[0] !== V_MIXED) begin
      n_err++; $display("FAIL post_reset_txn: got lat %0d data %h want lat 4 data %h", lat, out_data[0], V_MIXED);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [127:0] d;
    logic [127:0] exp_d;
    int pulses;
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_d = ref_mix(d, 1'b0);
    in_data = d; in_inverse = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready[0] && out_valid[0]) begin
        n_err++; $display("FAIL b2b_overlap cycle %0d: in_ready and out_valid both high", i);
      end
      if (out_valid[0]) begin
        pulses++;
        n_cmp++;
        if (out_data[0] !== exp_d) begin
          n_err++; $display("FAIL b2b_data pulse %0d: got %h want %h", pulses, out_data[0], exp_d);
        end
      end
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    n_cmp++;
    if (pulses != 5) begin
      n_err++; $display("FAIL b2b_throughput: got %0d results want 5", pulses);
    end
    for (int i = 0; i < 8; i++) begin
      out_ready[0] = out_valid[0];
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b0;
  endtask

  task automatic test_random_roundtrip;
    logic [127:0] d;
    logic [127:0] r1;
    logic [127:0] r2;
    logic         i1;
    logic         i2;
    int           l1;
    int           l2;
    int           k;
    for (int i = 0; i < 1000; i++) begin
      k = i % 3;
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(k, d, 1'b0, 1'b1, r1, i1, l1);
      n_cmp++;
      if (r1 !== ref_mix(d, 1'b0) || i1 !== 1'b0 || l1 != (4 >> k)) begin
        n_err++; $display("FAIL rand_fwd iter %0d inst %0d: got %h inv %b lat %0d want %h inv 0 lat %0d",
                          i, k, r1, i1, l1, ref_mix(d, 1'b0), 4 >> k);
      end
      run_txn(k, r1, 1'b1, 1'b1, r2, i2, l2);
      n_cmp++;
      if (r2 !== d || i2 !== 1'b1 || l2 != (4 >> k)) begin
        n_err++; $display("FAIL rand_roundtrip iter %0d inst %0d: got %h inv %b lat %0d want %h inv 1 lat %0d",
                          i, k, r2, i2, l2, d, 4 >> k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_reset_midcalc;
    test_back_to_back;
    test_random_roundtrip;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
